vga_timing_gen: RTL and testbench

//   Generates the 640x480@60 VGA raster that drives the overlay renderers (text, emblem).

---
 rtl/vga_timing_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster bundle between the VGA timing generator and its consumers.
//   pix_en       pixel-rate enable (driven by the consumer side / clock plumbing)
//   x, y         current raster position (10 bits each)
//   active       visible-area flag aligned with x/y
//   active_d     active delayed by the sync pipe depth
//   hsync/vsync  pad-level sync outputs (delayed, polarity applied)
//   line_start   one-clk strobe at x==0 on a pixel tick
//   frame_start  one-clk strobe at x==0,y==0 on a pixel tick
//   frame_count  completed-frame counter, wraps
interface vga_timing_if;
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       active_d;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        input  pix_en,
        output x, y, active, active_d, hsync, vsync,
        output line_start, frame_start, frame_count
    );

    modport slave (
        output pix_en,
        input  x, y, active, active_d, hsync, vsync,
        input  line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 style raster generator.
//   clk  system clock
//   rst  asynchronous active-high reset
//   vga  vga_timing_if master modport: pix_en in; x, y, active, active_d,
//        hsync, vsync, line_start, frame_start, frame_count out.
// x/y and active are undelayed. hsync/vsync/active_d pass through a
// PIPE_DELAY-deep shift register advancing on pix_en so they line up with
// pipelined pixel renderers downstream.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 2
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Geometry must fit the 10-bit counters, pipe depth is 0..7.
    generate
        if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_geometry
            $error("vga_timing_gen: H/V totals must be below 1024");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe
            $error("vga_timing_gen: PIPE_DELAY must be 0..7");
        end
    endgenerate

    logic       pix_en;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] frame_count_q, frame_count_d;

    assign pix_en = vga.pix_en;

    // Raster counters: x wraps into y, y wraps into the frame counter.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        frame_count_d = frame_count_q;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d           = '0;
                    frame_count_d = frame_count_q + 8'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            frame_count_q <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Raw decode. active is masked by rst since x=y=0 would otherwise
    // read as visible while the block is held in reset.
    logic hs_raw, vs_raw, act_raw;
    assign hs_raw  = (x_q >= HS_START) && (x_q < HS_END);
    assign vs_raw  = (y_q >= VS_START) && (y_q < VS_END);
    assign act_raw = !rst && (x_q < H_ACT_END) && (y_q < V_ACT_END);

    // Delay pipe, one stage per generate iteration; reset fills it with
    // the deasserted (raw=0) level so the pad sees no spurious sync pulse.
    logic hs_dly, vs_dly, act_dly;
    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign hs_dly  = hs_raw;
            assign vs_dly  = vs_raw;
            assign act_dly = act_raw;
        end else begin : g_pipe
            for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
                logic [2:0] stage_q, stage_d, stage_in;
                if (gi == 0) begin : g_src
                    assign stage_in = {act_raw, vs_raw, hs_raw};
                end else begin : g_src
                    assign stage_in = g_stage[gi-1].stage_q;
                end
                always_comb begin
                    stage_d = stage_q;
                    if (pix_en) begin
                        stage_d = stage_in;
                    end
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_q <= '0;
                    end else begin
                        stage_q <= stage_d;
                    end
                end
            end
            assign {act_dly, vs_dly, hs_dly} = g_stage[PIPE_DELAY-1].stage_q;
        end
    endgenerate

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.frame_count = frame_count_q;
    assign vga.active      = act_raw;
    assign vga.active_d    = act_dly;
    // Polarity is applied after the pipe so the pipe always carries raw decode.
    assign vga.hsync       = (SYNC_POL != 0) ? hs_dly : !hs_dly;
    assign vga.vsync       = (SYNC_POL != 0) ? vs_dly : !vs_dly;
    assign vga.line_start  = pix_en && !rst && (x_q == 10'd0);
    assign vga.frame_start = pix_en && !rst && (x_q == 10'd0) && (y_q == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Second instance uses a tiny raster so whole frames and the 8-bit
    // frame counter wrap fit in a short run; polarity and depth differ too.
    localparam int B_HA = 8, B_HFP = 2, B_HS = 3, B_HB = 2;
    localparam int B_VA = 4, B_VFP = 1, B_VS = 2, B_VB = 1;
    localparam int B_POL = 1, B_PD = 3;
    localparam int B_FRAME = (B_HA + B_HFP + B_HS + B_HB) * (B_VA + B_VFP + B_VS + B_VB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    int   t = 0;          // pixel ticks since last reset
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_if vif_a ();
    vga_timing_if vif_b ();
    assign vif_a.pix_en = pix_en;
    assign vif_b.pix_en = pix_en;

    vga_timing_gen u_a (
        .clk (clk),
        .rst (rst),
        .vga (vif_a.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (B_HA), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HB),
        .V_ACTIVE (B_VA), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VB),
        .SYNC_POL (B_POL), .PIPE_DELAY (B_PD)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .vga (vif_b.master)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) t <= 0;
        else if (pix_en) t <= t + 1;
    end

    typedef struct {
        int   x, y, fc;
        logic act, act_d, hsync, vsync, ls, fs;
    } exp_t;

    // Position is just the tick count folded by the raster size; delayed
    // outputs are the decode of the position PD ticks earlier.
    function automatic exp_t model(input int ha, hfp, hs, hb, va, vfp, vs, vb,
                                   input int pol, pd, tk, input logic r, pe);
        exp_t e;
        int ht, vt, xd, yd;
        logic hr, vr, ad;
        ht = ha + hfp + hs + hb;
        vt = va + vfp + vs + vb;
        e.x  = tk % ht;
        e.y  = (tk / ht) % vt;
        e.fc = (tk / (ht * vt)) % 256;
        e.act = !r && (e.x < ha) && (e.y < va);
        hr = 1'b0; vr = 1'b0; ad = 1'b0;
        if (tk >= pd) begin
            xd = (tk - pd) % ht;
            yd = ((tk - pd) / ht) % vt;
            hr = (xd >= ha + hfp) && (xd < ha + hfp + hs);
            vr = (yd >= va + vfp) && (yd < va + vfp + vs);
            ad = !r && (xd < ha) && (yd < va);
        end
        e.act_d = ad;
        e.hsync = (pol != 0) ? hr : !hr;
        e.vsync = (pol != 0) ? vr : !vr;
        e.ls = pe && !r && (e.x == 0);
        e.fs = e.ls && (e.y == 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", name, got, want, t, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t ea, eb;
        ea = model(640, 16, 96, 48, 480, 10, 2, 33, 0, 2, t, rst, pix_en);
        eb = model(B_HA, B_HFP, B_HS, B_HB, B_VA, B_VFP, B_VS, B_VB, B_POL, B_PD, t, rst, pix_en);
        check("a.x", 32'(vif_a.x), ea.x);
        check("a.y", 32'(vif_a.y), ea.y);
        check("a.frame_count", 32'(vif_a.frame_count), ea.fc);
        check("a.active", 32'(vif_a.active), 32'(ea.act));
        check("a.active_d", 32'(vif_a.active_d), 32'(ea.act_d));
        check("a.hsync", 32'(vif_a.hsync), 32'(ea.hsync));
        check("a.vsync", 32'(vif_a.vsync), 32'(ea.vsync));
        check("a.line_start", 32'(vif_a.line_start), 32'(ea.ls));
        check("a.frame_start", 32'(vif_a.frame_start), 32'(ea.fs));
        check("b.x", 32'(vif_b.x), eb.x);
        check("b.y", 32'(vif_b.y), eb.y);
        check("b.frame_count", 32'(vif_b.frame_count), eb.fc);
        check("b.active", 32'(vif_b.active), 32'(eb.act));
        check("b.active_d", 32'(vif_b.active_d), 32'(eb.act_d));
        check("b.hsync", 32'(vif_b.hsync), 32'(eb.hsync));
        check("b.vsync", 32'(vif_b.vsync), 32'(eb.vsync));
        check("b.line_start", 32'(vif_b.line_start), 32'(eb.ls));
        check("b.frame_start", 32'(vif_b.frame_start), 32'(eb.fs));
    end

    initial begin
        int fall_x, rise_x, low_cnt, last_fs, period, guard;
        logic prev_h, found, seen657, seen658, seen_a, seen_b;

        // Reset state, literal values.
        repeat (3) @(negedge clk);
        $display("txn reset: checking held-reset outputs");
        check("rst.a.x", 32'(vif_a.x), 0);
        check("rst.a.active", 32'(vif_a.active), 0);
        check("rst.a.active_d", 32'(vif_a.active_d), 0);
        check("rst.a.hsync", 32'(vif_a.hsync), 1);
        check("rst.a.vsync", 32'(vif_a.vsync), 1);
        check("rst.a.line_start", 32'(vif_a.line_start), 0);
        check("rst.b.hsync", 32'(vif_b.hsync), 0);

        // Release with pix_en=1: first tick is (0,0) visible with both strobes.
        @(posedge clk); #1; rst = 1'b0; pix_en = 1'b1;
        @(negedge clk);
        $display("txn release: x=%0d y=%0d active=%0b ls=%0b fs=%0b",
                 vif_a.x, vif_a.y, vif_a.active, vif_a.line_start, vif_a.frame_start);
        check("first.x", 32'(vif_a.x), 0);
        check("first.y", 32'(vif_a.y), 0);
        check("first.active", 32'(vif_a.active), 1);
        check("first.line_start", 32'(vif_a.line_start), 1);
        check("first.frame_start", 32'(vif_a.frame_start), 1);

        // First lines: hsync edges and the second line_start.
        fall_x = -1; rise_x = -1; low_cnt = 0; prev_h = vif_a.hsync;
        for (int k = 1; k <= 1700; k++) begin
            @(negedge clk);
            if (t == 800) begin
                check("line1.y", 32'(vif_a.y), 1);
                check("line1.line_start", 32'(vif_a.line_start), 1);
            end
            if (prev_h && !vif_a.hsync && fall_x < 0) fall_x = int'(vif_a.x);
            if (!prev_h && vif_a.hsync && fall_x >= 0 && rise_x < 0) rise_x = int'(vif_a.x);
            if (fall_x >= 0 && rise_x < 0 && !vif_a.hsync) low_cnt++;
            prev_h = vif_a.hsync;
        end
        $display("txn hsync: fall x=%0d rise x=%0d low=%0d", fall_x, rise_x, low_cnt);
        check("hsync.fall_x", 32'(fall_x), 658);
        check("hsync.rise_x", 32'(rise_x), 754);
        check("hsync.low_clks", 32'(low_cnt), 96);

        // pix_en toggling: small raster frame period doubles to 240 clks.
        last_fs = -1; period = -1;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1; pix_en = ~pix_en;
            @(negedge clk);
            if (vif_b.frame_start) begin
                if (last_fs >= 0 && period < 0) period = k - last_fs;
                last_fs = k;
            end
        end
        pix_en = 1'b1;
        $display("txn toggle: small-frame period=%0d clks", period);
        check("toggle.period", 32'(period), 2 * B_FRAME);

        // Mid-line asynchronous reset at x=300.
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (vif_a.x == 10'd300) found = 1'b1;
        end
        check("find.x300", 32'(found), 1);
        #1 rst = 1'b1;
        #1;
        $display("txn async-rst: x=%0d y=%0d active=%0b hsync=%0b",
                 vif_a.x, vif_a.y, vif_a.active, vif_a.hsync);
        check("arst.x", 32'(vif_a.x), 0);
        check("arst.y", 32'(vif_a.y), 0);
        check("arst.active", 32'(vif_a.active), 0);
        check("arst.hsync", 32'(vif_a.hsync), 1);
        check("arst.line_start", 32'(vif_a.line_start), 0);
        check("arst.b.x", 32'(vif_b.x), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel.frame_start", 32'(vif_a.frame_start), 1);
        seen657 = 1'b0; seen658 = 1'b0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (vif_a.x == 10'd657) begin
                seen657 = 1'b1;
                check("rel.hsync@657", 32'(vif_a.hsync), 1);
            end
            if (vif_a.x == 10'd658) begin
                seen658 = 1'b1;
                check("rel.hsync@658", 32'(vif_a.hsync), 0);
            end
        end
        check("rel.seen657", 32'(seen657), 1);
        check("rel.seen658", 32'(seen658), 1);

        // 256 small frames: frame_count wraps 255 -> 0.
        seen_a = 1'b0; seen_b = 1'b0; guard = 0;
        while (t < 256 * B_FRAME && guard < 40000) begin
            @(negedge clk);
            guard++;
            if (t == 256 * B_FRAME - 1) begin
                seen_a = 1'b1;
                check("wrap.fc255", 32'(vif_b.frame_count), 255);
            end
            if (t == 256 * B_FRAME) begin
                seen_b = 1'b1;
                check("wrap.fc0", 32'(vif_b.frame_count), 0);
                check("wrap.frame_start", 32'(vif_b.frame_start), 1);
            end
        end
        $display("txn wrap: t=%0d frame_count=%0d", t, vif_b.frame_count);
        check("wrap.seen255", 32'(seen_a), 1);
        check("wrap.seen0", 32'(seen_b), 1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
